gcd_ctrl: RTL and testbench

//  Control-path FSM sequencing the 16-bit subtract-and-compare GCD datapath (A/B PIPO regs,

---
 rtl/gcd_ctrl_pkg.sv | 66 ++++++
 rtl/gcd_iter_cnt.sv | 35 +++
 rtl/gcd_ctrl.sv | 97 +++++++++
 tb/tb_gcd_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_ctrl_pkg.sv
// Shared definitions for the GCD control path: FSM state encoding
// and the mux-select values driven onto the datapath.
package gcd_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_CMP    = 3'd3,
        S_SUB_A  = 3'd4,
        S_SUB_B  = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    localparam logic SUB_A_MINUS_B = 1'b0;
    localparam logic SUB_B_MINUS_A = 1'b1;
    localparam logic IN_SEL_BUS    = 1'b1;
    localparam logic IN_SEL_SUB    = 1'b0;

    // Moore control word for one FSM state.
    typedef struct packed {
        logic ld_a;
        logic ld_b;
        logic in_sel;
        logic sub_sel;
        logic busy;
        logic done;
        logic err;
    } ctrl_t;

    function automatic ctrl_t decode(state_t s);
        ctrl_t c;
        c = '0;
        unique case (s)
            S_IDLE: ;
            S_LOAD_A: begin
                c.ld_a   = 1'b1;
                c.in_sel = IN_SEL_BUS;
                c.busy   = 1'b1;
            end
            S_LOAD_B: begin
                c.ld_b   = 1'b1;
                c.in_sel = IN_SEL_BUS;
                c.busy   = 1'b1;
            end
            S_CMP: c.busy = 1'b1;
            S_SUB_A: begin
                c.ld_a    = 1'b1;
                c.in_sel  = IN_SEL_SUB;
                c.sub_sel = SUB_A_MINUS_B;
                c.busy    = 1'b1;
            end
            S_SUB_B: begin
                c.ld_b    = 1'b1;
                c.in_sel  = IN_SEL_SUB;
                c.sub_sel = SUB_B_MINUS_A;
                c.busy    = 1'b1;
            end
            S_DONE: c.done = 1'b1;
            S_ERR:  c.err  = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/gcd_iter_cnt.sv
// Subtraction counter for the GCD control path.
// Ports: clk, rst_n (sync, active low), clr, inc, count, last
// (last = the increment now in progress reaches MAX_ITER).
module gcd_iter_cnt #(
    parameter int          CNT_W    = 16,
    parameter int unsigned MAX_ITER = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(MAX_ITER - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Limit is known one count early so the FSM can leave SUB_* for ERR
    // on the same edge that performs the final increment.
    assign last  = (cnt == LAST_VAL);
    assign count = cnt;

endmodule

// File: rtl/gcd_ctrl.sv
// Control FSM for the subtract-and-compare GCD datapath.
// Ports: clk, rst_n, start, abort, done_ack, lt/gt/eq in; ld_a, ld_b,
// in_sel, sub_sel, busy, done, err, iter_count out (all Moore).
module gcd_ctrl
    import gcd_ctrl_pkg::*;
#(
    parameter int          CNT_W    = 16,
    parameter int unsigned MAX_ITER = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             done_ack,
    input  logic             lt,
    input  logic             gt,
    input  logic             eq,
    output logic             ld_a,
    output logic             ld_b,
    output logic             in_sel,
    output logic             sub_sel,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] iter_count
);

    state_t state;
    state_t nxt;
    logic   cnt_clr;
    logic   cnt_inc;
    logic   cnt_last;
    ctrl_t  ctrl;

    // Abort freezes the count at whatever it held.
    assign cnt_clr = (state == S_LOAD_A) && !abort;
    assign cnt_inc = ((state == S_SUB_A) || (state == S_SUB_B)) && !abort;

    gcd_iter_cnt #(
        .CNT_W    (CNT_W),
        .MAX_ITER (MAX_ITER)
    ) u_iter_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (iter_count),
        .last  (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        if (abort) begin
            nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:   if (start) nxt = S_LOAD_A;
                S_LOAD_A: nxt = S_LOAD_B;
                S_LOAD_B: nxt = S_CMP;
                S_CMP: begin
                    // eq dominates; no flag at all keeps comparing.
                    if (eq) begin
                        nxt = S_DONE;
                    end else if (gt) begin
                        nxt = S_SUB_A;
                    end else if (lt) begin
                        nxt = S_SUB_B;
                    end
                end
                S_SUB_A,
                S_SUB_B:  nxt = cnt_last ? S_ERR : S_CMP;
                S_DONE,
                S_ERR:    if (done_ack) nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ctrl    = decode(state);
        ld_a    = ctrl.ld_a;
        ld_b    = ctrl.ld_b;
        in_sel  = ctrl.in_sel;
        sub_sel = ctrl.sub_sel;
        busy    = ctrl.busy;
        done    = ctrl.done;
        err     = ctrl.err;
    end

endmodule

// File: tb/tb_gcd_ctrl.sv
// Bench for gcd_ctrl: two controllers (limits 8 and 64) each driving
// a behavioural A/B datapath, checked every cycle against a run model.
module tb_gcd_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic        abort;
    logic        done_ack;
    logic [15:0] data_in;

    logic        lt_v      [2];
    logic        gt_v      [2];
    logic        eq_v      [2];
    logic        ld_a_v    [2];
    logic        ld_b_v    [2];
    logic        in_sel_v  [2];
    logic        sub_sel_v [2];
    logic        busy_v    [2];
    logic        done_v    [2];
    logic        err_v     [2];
    logic [15:0] itc       [2];
    logic [15:0] dpa       [2];

    int maxv [2] = '{8, 64};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int unsigned MX = (g == 0) ? 8 : 64;
        logic [15:0] ra = '0;
        logic [15:0] rb = '0;
        logic [15:0] sub_r;
        assign sub_r = sub_sel_v[g] ? (rb - ra) : (ra - rb);
        always @(posedge clk) begin
            if (ld_a_v[g]) ra <= in_sel_v[g] ? data_in : sub_r;
            if (ld_b_v[g]) rb <= in_sel_v[g] ? data_in : sub_r;
        end
        assign lt_v[g] = ra < rb;
        assign gt_v[g] = ra > rb;
        assign eq_v[g] = ra == rb;
        assign dpa[g]  = ra;

        gcd_ctrl #(
            .CNT_W    (16),
            .MAX_ITER (MX)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start      (start),
            .abort      (abort),
            .done_ack   (done_ack),
            .lt         (lt_v[g]),
            .gt         (gt_v[g]),
            .eq         (eq_v[g]),
            .ld_a       (ld_a_v[g]),
            .ld_b       (ld_b_v[g]),
            .in_sel     (in_sel_v[g]),
            .sub_sel    (sub_sel_v[g]),
            .busy       (busy_v[g]),
            .done       (done_v[g]),
            .err        (err_v[g]),
            .iter_count (itc[g])
        );
    end

    typedef struct {
        int          cyc;
        logic [6:0]  o;
        logic [15:0] it;
    } ent_t;

    // o = {busy, done, err, ld_a, ld_b, in_sel, sub_sel}
    localparam logic [6:0] O_IDLE = 7'b000_0000;
    localparam logic [6:0] O_LDA  = 7'b100_1010;
    localparam logic [6:0] O_LDB  = 7'b100_0110;
    localparam logic [6:0] O_CMP  = 7'b100_0000;
    localparam logic [6:0] O_SUBA = 7'b100_1000;
    localparam logic [6:0] O_SUBB = 7'b100_0101;
    localparam logic [6:0] O_DONE = 7'b010_0000;
    localparam logic [6:0] O_ERR  = 7'b001_0000;

    ent_t q       [2][$];
    ent_t exp_cur [2];
    bit   chk_en = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   term_c [2];

    function automatic ent_t mk(int t, logic [6:0] o, logic [15:0] it);
        ent_t e;
        e.cyc = t;
        e.o   = o;
        e.it  = it;
        return e;
    endfunction

    // Plain subtractive Euclid with an iteration limit.
    function automatic logic [15:0] model_run(
        input  logic [15:0] a,
        input  logic [15:0] b,
        input  int          mx,
        output int          n,
        output bit          lim
    );
        logic [15:0] x = a;
        logic [15:0] y = b;
        n   = 0;
        lim = 1'b0;
        while (x != y && !lim) begin
            if (x > y) x = x - y;
            else       y = y - x;
            n++;
            if (n == mx) lim = 1'b1;
        end
        return x;
    endfunction

    function automatic logic [15:0] iter_at(int i, int now);
        logic [15:0] v = exp_cur[i].it;
        foreach (q[i][k]) if (q[i][k].cyc <= now) v = q[i][k].it;
        return v;
    endfunction

    function automatic void cut(int i, int now);
        while (q[i].size() > 0 && q[i][q[i].size()-1].cyc > now)
            void'(q[i].pop_back());
    endfunction

    // Expected per-cycle trace of a run whose start is sampled at end of c.
    function automatic void push_run(int i, logic [15:0] a, logic [15:0] b, int c);
        logic [15:0] x = a;
        logic [15:0] y = b;
        int t = c + 1;
        int n = 0;
        q[i].push_back(mk(t, O_LDA, iter_at(i, c)));
        t++;
        q[i].push_back(mk(t, O_LDB, 16'd0));
        t++;
        while (1) begin
            q[i].push_back(mk(t, O_CMP, 16'(n)));
            t++;
            if (x == y) begin
                q[i].push_back(mk(t, O_DONE, 16'(n)));
                break;
            end
            if (x > y) begin
                q[i].push_back(mk(t, O_SUBA, 16'(n)));
                x = x - y;
            end else begin
                q[i].push_back(mk(t, O_SUBB, 16'(n)));
                y = y - x;
            end
            t++;
            n++;
            if (n == maxv[i]) begin
                q[i].push_back(mk(t, O_ERR, 16'(n)));
                break;
            end
        end
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [22:0] got;
            logic [22:0] want;
            while (q[i].size() > 0 && q[i][0].cyc <= cyc)
                exp_cur[i] = q[i].pop_front();
            if (chk_en) begin
                got  = {busy_v[i], done_v[i], err_v[i], ld_a_v[i], ld_b_v[i],
                        in_sel_v[i], sub_sel_v[i], itc[i]};
                want = {exp_cur[i].o, exp_cur[i].it};
                n_chk++;
                if (got === want) n_pass++;
                else $display("FAIL cyc%0d inst%0d outputs got=%h want=%h",
                              cyc, i, got, want);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=%0d want=%0d", name, got, want);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [15:0] a, input logic [15:0] b, output int c);
        c = cyc;
        for (int i = 0; i < 2; i++) push_run(i, a, b, c);
        start = 1'b1;
        step();
        start   = 1'b0;
        data_in = a;
        step();
        data_in = b;
        step();
        data_in = '0;
    endtask

    task automatic wait_term();
        bit ok = 1'b0;
        term_c = '{-1, -1};
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 2; i++)
                if (term_c[i] < 0 && (done_v[i] || err_v[i])) term_c[i] = cyc;
            if (term_c[0] >= 0 && term_c[1] >= 0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) begin
            n_chk++;
            $display("FAIL wait_term timeout got=%0d,%0d want=terminal",
                     term_c[0], term_c[1]);
        end
    endtask

    // Jump both model traces to IDLE on the next edge (ack/abort).
    task automatic go_idle();
        for (int i = 0; i < 2; i++) begin
            logic [15:0] h = iter_at(i, cyc);
            cut(i, cyc);
            q[i].push_back(mk(cyc + 1, O_IDLE, h));
        end
    endtask

    task automatic ack();
        done_ack = 1'b1;
        go_idle();
        step();
        done_ack = 1'b0;
    endtask

    int          c;
    int          mn;
    bit          ml;
    logic [15:0] mg;

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        done_ack = 1'b0;
        data_in  = '0;
        exp_cur  = '{mk(0, O_IDLE, 16'd0), mk(0, O_IDLE, 16'd0)};
        step();
        step();
        chk_en = 1'b1;
        rst_n  = 1'b1;
        step();

        mg = model_run(16'd12, 16'd8, 64, mn, ml);
        chk("pin 12,8 gcd", 32'(mg), 4);
        chk("pin 12,8 n", mn, 2);
        mg = model_run(16'd1071, 16'd462, 64, mn, ml);
        chk("pin 1071,462 gcd", 32'(mg), 21);
        chk("pin 1071,462 n", mn, 11);
        mg = model_run(16'd0, 16'd5, 8, mn, ml);
        chk("pin 0,5 n", mn, 8);
        chk("pin 0,5 lim", 32'(ml), 1);

        // equal operands
        run(16'd12, 16'd12, c);
        wait_term();
        chk("t1 done cycle", term_c[0] - c, 4);
        chk("t1 A", 32'(dpa[0]), 12);
        chk("t1 iter", 32'(itc[0]), 0);
        ack();
        chk("t1 busy after", 32'(busy_v[0]), 0);

        // two subtractions
        run(16'd12, 16'd8, c);
        wait_term();
        chk("t2 done cycle", term_c[1] - c, 8);
        chk("t2 A", 32'(dpa[1]), 4);
        chk("t2 iter", 32'(itc[1]), 2);
        ack();

        // one operand zero hits the limit
        run(16'd0, 16'd5, c);
        wait_term();
        chk("t3 err cycle lim8", term_c[0] - c, 19);
        chk("t3 iter lim8", 32'(itc[0]), 8);
        chk("t3 done lim8", 32'(done_v[0]), 0);
        chk("t3 err cycle lim64", term_c[1] - c, 131);
        ack();

        // long run: completes under 64, errors under 8
        run(16'd1071, 16'd462, c);
        wait_term();
        chk("t4 A", 32'(dpa[1]), 21);
        chk("t4 iter", 32'(itc[1]), 11);
        chk("t4 err lim8", 32'(err_v[0]), 1);
        ack();

        // both zero
        run(16'd0, 16'd0, c);
        wait_term();
        chk("t4b done cycle", term_c[0] - c, 4);
        chk("t4b A", 32'(dpa[0]), 0);
        ack();

        // abort in SUB_A, then a clean run
        run(16'd12, 16'd8, c);
        step();
        abort = 1'b1;
        go_idle();
        step();
        abort = 1'b0;
        repeat (3) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        run(16'd9, 16'd6, c);
        wait_term();
        chk("t5 A", 32'(dpa[0]), 3);
        chk("t5 iter", 32'(itc[0]), 2);
        ack();

        // reset in CMP
        run(16'd12, 16'd8, c);
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cut(i, cyc);
            q[i].push_back(mk(cyc + 1, O_IDLE, 16'd0));
        end
        step();
        rst_n = 1'b1;
        step();
        chk("t6 iter after reset", 32'(itc[0]), 0);

        // start ignored in DONE; start+ack only returns to IDLE
        run(16'd12, 16'd12, c);
        wait_term();
        start = 1'b1;
        repeat (3) step();
        done_ack = 1'b1;
        go_idle();
        step();
        start    = 1'b0;
        done_ack = 1'b0;
        repeat (3) step();
        chk("t6 busy idle", 32'(busy_v[0]), 0);
        chk("t6 done idle", 32'(done_v[1]), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
